// File: rtl/multi_port_circular_buffer_if.sv
// Handshake/data bundle for multi_port_circular_buffer.
// The master side (producer/consumer logic) drives requests; the slave side is the buffer.
interface multi_port_circular_buffer_if #(
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 3,
  parameter int DEPTH     = 7,
  parameter int BITS      = 12
) ();
  localparam int WN_W  = $clog2(PAR_WRITE + 1);
  localparam int RN_W  = $clog2(PAR_READ + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      flush;
  logic                      write_en;
  logic [WN_W-1:0]           wr_num;
  logic [PAR_WRITE*BITS-1:0] din;
  logic                      ready;
  logic                      read_en;
  logic [RN_W-1:0]           rd_num;
  logic [PAR_READ*BITS-1:0]  dout;
  logic                      valid;
  logic [CNT_W-1:0]          count;
  logic                      almost_full;
  logic                      almost_empty;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output flush, write_en, wr_num, din, read_en, rd_num,
    input  ready, dout, valid, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, write_en, wr_num, din, read_en, rd_num,
    output ready, dout, valid, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/multi_port_circular_buffer.sv
// Circular FIFO accepting 1..PAR_WRITE words and releasing 1..PAR_READ words per cycle.
// dout is a zero-latency window of the PAR_READ oldest entries.
// Optional feature macro: BUF_ERR_FLAGS_EN (sticky overflow/underflow flags with warnings);
// when undefined, overflow/underflow are tied low.
module multi_port_circular_buffer #(
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 3,
  parameter int DEPTH     = 7,
  parameter int BITS      = 12,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1
) (
  input logic                          clk,
  input logic                          rst,
  multi_port_circular_buffer_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PAR_WRITE);
  localparam logic [CNT_W-1:0] PR_C    = CNT_W'(PAR_READ);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  if (DEPTH < PAR_WRITE || DEPTH < PAR_READ) begin : g_bad_depth
    $error("multi_port_circular_buffer: DEPTH must be >= max(PAR_WRITE, PAR_READ)");
  end

  logic [BITS-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] wr_n, rd_n;
  logic             wr_acc, rd_acc;
  logic             wr_rej, rd_rej;

  // Pointer advance with compare-and-subtract; p < DEPTH and n <= DEPTH keep the sum below 2*DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p) + SUM_W'(n);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Acceptance decode against start-of-cycle count/free; flush discards both requests.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    free   = DEPTH_C - count;
    wr_n   = CNT_W'(bus.wr_num);
    rd_n   = CNT_W'(bus.rd_num);
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    wr_rej = 1'b0;
    rd_rej = 1'b0;
    if (!bus.flush) begin
      wr_acc = bus.write_en && (wr_n != '0) && (wr_n <= free);
      rd_acc = bus.read_en  && (rd_n != '0) && (rd_n <= count);
      wr_rej = bus.write_en && (wr_n > free);
      rd_rej = bus.read_en  && (rd_n > count);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_add(wr_ptr, wr_n);
      if (rd_acc) rd_ptr <= ptr_add(rd_ptr, rd_n);
      count <= count + (wr_acc ? wr_n : '0) - (rd_acc ? rd_n : '0);
    end
  end

  // Storage write of words 0..wr_num-1 starting at wr_ptr.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates what is meaningful, and this keeps it plain RAM.
    for (int k = 0; k < PAR_WRITE; k++) begin
      if (wr_acc && (CNT_W'(k) < wr_n)) begin
        mem[ptr_add(wr_ptr, CNT_W'(k))] <= bus.din[k*BITS +: BITS];
      end
    end
  end

  // Zero-latency read window: word i is the entry at rd_ptr+i.
  always_comb begin
    bus.dout = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      bus.dout[i*BITS +: BITS] = mem[ptr_add(rd_ptr, CNT_W'(i))];
    end
  end

  // Status flags decoded from the registered count.
  always_comb begin
    bus.count        = count;
    bus.ready        = free >= PW_C;
    bus.valid        = count >= PR_C;
    bus.almost_full  = count >= AF_C;
    bus.almost_empty = count <= AE_C;
  end

`ifdef BUF_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_rej) overflow_q  <= 1'b1;
      if (rd_rej) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // Simulation warnings for rejected requests.
  always @(posedge clk) begin
    if (rst && wr_rej) $display("multi_port_circular_buffer warning: write of %0d words, %0d free", wr_n, free);
    if (rst && rd_rej) $display("multi_port_circular_buffer warning: read of %0d words, %0d held", rd_n, count);
  end
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
